// File: rtl/custom_fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NUM_REQ valid/ready requesters.
// Grants bursts of up to BURST_LEN beats; writes are registered onto wen_o/din_o.
module custom_fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATASIZE  = 8,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  input  logic [NUM_REQ*DATASIZE-1:0]  req_data_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  output logic [NUM_REQ-1:0]           grant_o,
  output logic                         busy_o,
  output logic                         wen_o,
  output logic [DATASIZE-1:0]          din_o,
  input  logic                         fifo_full_i,
  input  logic                         fifo_almost_full_i,
  output logic [CNT_W-1:0]             wr_count_o
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BEAT_W = $clog2(BURST_LEN + 1);
  localparam logic [IDX_W:0]    NUM_REQ_L = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;

  state_t                state_r, state_nxt_s;
  logic [NUM_REQ-1:0]    grant_r;
  logic [IDX_W-1:0]      gidx_r, rr_ptr_r;
  logic [BEAT_W-1:0]     beat_cnt_r;
  logic                  wen_r;
  logic [DATASIZE-1:0]   din_r;
  logic [CNT_W-1:0]      wr_count_r;

  logic                  sel_found_s;
  logic [IDX_W-1:0]      sel_idx_s;
  logic [IDX_W:0]        cand_s;
  logic [DATASIZE-1:0]   data_g_s;
  logic                  valid_g_s, ready_s, beat_s, exit_s;
  logic [NUM_REQ-1:0]    req_ready_s;
  logic                  busy_s;

  // Round-robin pick: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = '0;
    cand_s      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s = {1'b0, rr_ptr_r} + (IDX_W+1)'(i);
      if (cand_s >= NUM_REQ_L) cand_s = cand_s - NUM_REQ_L;
      else                     cand_s = cand_s;
      if (!sel_found_s && req_valid_i[cand_s[IDX_W-1:0]]) begin
        sel_found_s = 1'b1;
        sel_idx_s   = cand_s[IDX_W-1:0];
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // Data of the granted requester (grant is one-hot, so an OR-mux is exact).
  always_comb begin
    data_g_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_r[k]) data_g_s = data_g_s | req_data_i[k*DATASIZE +: DATASIZE];
      else            data_g_s = data_g_s;
    end
  end

  // Ready also drops when the write in flight may consume the last free slot.
  assign valid_g_s = |(req_valid_i & grant_r);
  assign ready_s   = (state_r == ST_GRANT) && !fifo_full_i && !(wen_r && fifo_almost_full_i);
  assign beat_s    = valid_g_s && ready_s;
  assign exit_s    = (state_r == ST_GRANT) && ((beat_s && (beat_cnt_r == LAST_BEAT)) || !valid_g_s);

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_r <= ST_IDLE;
    else       state_r <= state_nxt_s;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (sel_found_s) state_nxt_s = ST_GRANT;
        else             state_nxt_s = ST_IDLE;
      end
      ST_GRANT: begin
        if (exit_s) state_nxt_s = ST_IDLE;
        else        state_nxt_s = ST_GRANT;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output decode.
  always_comb begin
    req_ready_s = '0;
    busy_s      = 1'b0;
    if (state_r == ST_GRANT) busy_s = 1'b1;
    else                     busy_s = 1'b0;
    if (ready_s) req_ready_s = grant_r;
    else         req_ready_s = '0;
  end

  // Grant, round-robin pointer and burst beat counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      grant_r    <= '0;
      gidx_r     <= '0;
      rr_ptr_r   <= '0;
      beat_cnt_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (sel_found_s) begin
            grant_r <= {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_idx_s;
            gidx_r  <= sel_idx_s;
          end
        end
        ST_GRANT: begin
          if (exit_s) begin
            grant_r    <= '0;
            beat_cnt_r <= '0;
            rr_ptr_r   <= (gidx_r == LAST_IDX) ? '0 : gidx_r + IDX_W'(1);
          end else if (beat_s) begin
            beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
          end
        end
        default: begin
          grant_r    <= '0;
          beat_cnt_r <= '0;
        end
      endcase
    end
  end

  // Registered FIFO write port and total-write counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wen_r      <= 1'b0;
      din_r      <= '0;
      wr_count_r <= '0;
    end else begin
      wen_r      <= beat_s;
      wr_count_r <= wr_count_r + CNT_W'(wen_r);
      if (beat_s) din_r <= data_g_s;
    end
  end

  assign grant_o     = grant_r;
  assign req_ready_o = req_ready_s;
  assign busy_o      = busy_s;
  assign wen_o       = wen_r;
  assign din_o       = din_r;
  assign wr_count_o  = wr_count_r;

  custom_fifo_wr_arbiter_chk #(.NUM_REQ(NUM_REQ)) u_chk (
    .clk       (clk_i),
    .rst       (rst_i),
    .grant     (grant_r),
    .ready     (req_ready_s),
    .wen       (wen_r),
    .fifo_full (fifo_full_i)
  );

endmodule

// Invariant checker for the arbiter outputs.
module custom_fifo_wr_arbiter_chk #(
  parameter int NUM_REQ = 4
) (
  input logic               clk,
  input logic               rst,
  input logic [NUM_REQ-1:0] grant,
  input logic [NUM_REQ-1:0] ready,
  input logic               wen,
  input logic               fifo_full
);
  a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
  a_ready_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(ready));
  a_no_wr_after_full: assert property (@(posedge clk) disable iff (rst) $past(fifo_full) |-> !wen);
endmodule

// File: tb/tb_custom_fifo_wr_arbiter.sv
// Directed bench for custom_fifo_wr_arbiter: per-cycle behavioural model compare plus
// hand-computed expectations for each scenario.
module tb_custom_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int BL = 4;

  logic        clk, rst;
  logic [3:0]  req_valid, req_ready, grant;
  logic [31:0] req_data;
  logic        busy, wen, fifo_full, fifo_af;
  logic [7:0]  din;
  logic [15:0] wr_count;

  custom_fifo_wr_arbiter #(.NUM_REQ(N), .DATASIZE(8), .BURST_LEN(BL), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_ready_o(req_ready), .grant_o(grant), .busy_o(busy), .wen_o(wen), .din_o(din),
    .fifo_full_i(fifo_full), .fifo_almost_full_i(fifo_af), .wr_count_o(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Requester queues
  logic [7:0] rq_mem [N][32];
  int         head [N];
  int         tail [N];

  task automatic push(input int k, input logic [7:0] d);
    rq_mem[k][tail[k]] = d;
    tail[k]++;
  endtask

  task automatic drive_reqs();
    for (int k = 0; k < N; k++) begin
      req_valid[k]       = (head[k] < tail[k]);
      req_data[k*8 +: 8] = (head[k] < tail[k]) ? rq_mem[k][head[k]] : 8'h00;
    end
  endtask

  // Behavioural model: who holds the grant (-1 = nobody), pointer, beats, pending write
  int         m_g = -1, m_ptr = 0, m_beats = 0, m_count = 0;
  bit         m_wen = 1'b0;
  logic [7:0] m_din = 8'h00;

  always @(posedge clk or posedge rst) begin : model
    int g_n, p_n, b_n, c;
    bit w_n, rdy, leave;
    logic [7:0] d_n;
    if (rst) begin
      m_g <= -1; m_ptr <= 0; m_beats <= 0; m_wen <= 1'b0; m_din <= 8'h00; m_count <= 0;
    end else begin
      g_n = m_g; p_n = m_ptr; b_n = m_beats; w_n = 1'b0; d_n = m_din; leave = 1'b0;
      if (m_g < 0) begin
        for (int i = 0; i < N; i++) begin
          c = (m_ptr + i) % N;
          if (g_n < 0 && req_valid[c]) g_n = c;
        end
      end else begin
        rdy = !fifo_full && !(m_wen && fifo_af);
        if (req_valid[m_g] && rdy) begin
          w_n = 1'b1;
          d_n = req_data[m_g*8 +: 8];
          b_n = m_beats + 1;
          if (b_n == BL) leave = 1'b1;
        end else if (!req_valid[m_g]) begin
          leave = 1'b1;
        end
        if (leave) begin
          p_n = (m_g + 1) % N;
          g_n = -1;
          b_n = 0;
        end
      end
      m_count <= (m_count + int'(m_wen)) % 65536;
      m_g <= g_n; m_ptr <= p_n; m_beats <= b_n; m_wen <= w_n; m_din <= d_n;
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin : compare
    logic [3:0] eg, er;
    eg = (m_g >= 0) ? (4'b0001 << m_g) : 4'b0000;
    er = (m_g >= 0 && !fifo_full && !(m_wen && fifo_af)) ? eg : 4'b0000;
    check("cyc_grant", grant, eg);
    check("cyc_ready", req_ready, er);
    check("cyc_busy", busy, m_g >= 0);
    check("cyc_wen", wen, m_wen);
    check("cyc_din", din, m_din);
    check("cyc_wr_count", wr_count, m_count);
  end

  // Observation logs and a simple FIFO occupancy model
  logic [7:0]  wr_log[$];
  logic [3:0]  grant_seq[$];
  logic [15:0] cnt_at_grant[$];
  int          bursts[$];
  logic [3:0]  prev_grant;
  int          cur_burst, occ, overflow;
  bit          fifo_auto;

  task automatic tick();
    logic [3:0] fire;
    bit wen_seen;
    @(negedge clk);
    fire = req_valid & req_ready;
    if (wen) wr_log.push_back(din);
    if (grant != 4'b0000 && grant != prev_grant) begin
      grant_seq.push_back(grant);
      cnt_at_grant.push_back(wr_count);
    end
    if (grant != 4'b0000) begin
      if (fire != 4'b0000) cur_burst++;
    end else if (cur_burst > 0) begin
      bursts.push_back(cur_burst);
      cur_burst = 0;
    end
    prev_grant = grant;
    wen_seen = wen;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) if (fire[k]) head[k]++;
    if (fifo_auto) begin
      if (wen_seen) begin
        if (occ >= 16) overflow++;
        else occ++;
      end
      fifo_full = (occ == 16);
      fifo_af   = (occ >= 15);
    end
    drive_reqs();
    #1;
  endtask

  task automatic clear_logs();
    wr_log.delete(); grant_seq.delete(); cnt_at_grant.delete(); bursts.delete();
    prev_grant = 4'b0000; cur_burst = 0;
  endtask

  task automatic reset_dut();
    rst = 1'b1; fifo_full = 1'b0; fifo_af = 1'b0; fifo_auto = 1'b0; occ = 0; overflow = 0;
    for (int k = 0; k < N; k++) begin head[k] = 0; tail[k] = 0; end
    drive_reqs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_logs();
    #1;
  endtask

  initial begin
    logic [3:0] exp_g [5];
    rst = 1'b1; fifo_full = 1'b0; fifo_af = 1'b0;
    req_valid = 4'b0000; req_data = 32'h0;
    #1;
    check("rst_grant", grant, 4'b0000);
    check("rst_wen", wen, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_wr_count", wr_count, 16'd0);
    reset_dut();

    // Single requester 2, three beats
    push(2, 8'hA0); push(2, 8'hA1); push(2, 8'hA2);
    drive_reqs();
    repeat (8) tick();
    check("t1_ngrants", grant_seq.size(), 1);
    if (grant_seq.size() > 0) check("t1_grant", grant_seq[0], 4'b0100);
    check("t1_nwr", wr_log.size(), 3);
    for (int i = 0; i < 3; i++) if (i < wr_log.size()) check("t1_data", wr_log[i], 8'hA0 + 8'(i));
    check("t1_wr_count", wr_count, 16'd3);
    check("t1_idle", busy, 1'b0);

    // All requesters continuously valid: rotation 0,1,2,3,0
    reset_dut();
    for (int k = 0; k < N; k++) for (int i = 0; i < 8; i++) push(k, 8'(k*16 + i));
    drive_reqs();
    for (int i = 0; i < 80 && grant_seq.size() < 5; i++) tick();
    check("t2_rot_done", grant_seq.size() >= 5, 1'b1);
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 5; i++) if (i < grant_seq.size()) check("t2_order", grant_seq[i], exp_g[i]);
    if (cnt_at_grant.size() >= 5) check("t2_count16", cnt_at_grant[4], 16'd16);
    for (int i = 0; i < 4; i++) if (i < bursts.size()) check("t2_burst_len", bursts[i], 4);
    if (wr_log.size() > 4) check("t2_data4", wr_log[4], 8'h10);

    // FIFO full after two beats of a burst
    reset_dut();
    for (int i = 0; i < 6; i++) push(0, 8'hC0 + 8'(i));
    drive_reqs();
    for (int i = 0; i < 10 && head[0] < 2; i++) tick();
    check("t3_two_beats", head[0], 2);
    fifo_full = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t3_ready_low", req_ready, 4'b0000);
      check("t3_wen_low", wen, 1'b0);
      check("t3_grant_held", grant, 4'b0001);
    end
    fifo_full = 1'b0;
    #1;
    repeat (15) tick();
    check("t3_nbursts", bursts.size(), 2);
    if (bursts.size() > 1) begin
      check("t3_burst0", bursts[0], 4);
      check("t3_burst1", bursts[1], 2);
    end
    check("t3_wr_count", wr_count, 16'd6);

    // Almost-full with a write in flight drops ready for one cycle
    reset_dut();
    for (int i = 0; i < 4; i++) push(1, 8'hB0 + 8'(i));
    drive_reqs();
    for (int i = 0; i < 10 && !wen; i++) tick();
    check("t4_wen_seen", wen, 1'b1);
    fifo_af = 1'b1;
    #1;
    check("t4_af_ready_low", req_ready, 4'b0000);
    tick();
    check("t4_af_ready_back", req_ready, 4'b0010);
    fifo_af = 1'b0;
    repeat (10) tick();

    // Fill a 16-deep FIFO model with all requesters active
    reset_dut();
    fifo_auto = 1'b1;
    for (int k = 0; k < N; k++) for (int i = 0; i < 8; i++) push(k, 8'(8'h80 + k*8 + i));
    drive_reqs();
    repeat (60) tick();
    check("t4_occ", occ, 16);
    check("t4_overflow", overflow, 0);
    check("t4_wr_count", wr_count, 16'd16);
    check("t4_full_ready", req_ready, 4'b0000);

    // Requester 1 drops valid after one beat; requester 2 wins next
    reset_dut();
    push(1, 8'h51); push(2, 8'h61); push(2, 8'h62);
    drive_reqs();
    for (int i = 0; i < 10 && head[1] < 1; i++) tick();
    check("t5_r1_beat", head[1], 1);
    tick();
    push(1, 8'h52);
    drive_reqs();
    #1;
    repeat (20) tick();
    check("t5_ngrants", grant_seq.size(), 3);
    exp_g = '{4'b0010, 4'b0100, 4'b0010, 4'b0000, 4'b0000};
    for (int i = 0; i < 3; i++) if (i < grant_seq.size()) check("t5_order", grant_seq[i], exp_g[i]);
    if (bursts.size() > 1) begin
      check("t5_burst0", bursts[0], 1);
      check("t5_burst1", bursts[1], 2);
    end

    // Asynchronous reset mid-burst, then restart from requester 0
    reset_dut();
    for (int k = 0; k < N; k++) for (int i = 0; i < 8; i++) push(k, 8'(8'hE0 + k*8 + i));
    drive_reqs();
    for (int i = 0; i < 40 && grant != 4'b0100; i++) tick();
    check("t6_reach_r2", grant, 4'b0100);
    tick();
    #2 rst = 1'b1;
    #1;
    check("t6_wen", wen, 1'b0);
    check("t6_grant", grant, 4'b0000);
    check("t6_ready", req_ready, 4'b0000);
    check("t6_wr_count", wr_count, 16'd0);
    check("t6_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_logs();
    #1;
    for (int i = 0; i < 10 && grant_seq.size() == 0; i++) tick();
    check("t6_restart_n", grant_seq.size(), 1);
    if (grant_seq.size() > 0) check("t6_restart_r0", grant_seq[0], 4'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
